// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one downstream sram-like master port between the
// core's instruction-fetch and data-access sram-like ports.
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   inst_* (req/wr/size/addr/wdata)   instruction-side request inputs
//   inst_addr_ok/data_ok/rdata        instruction-side responses
//   data_*                            data-side, same shape as inst_*
//   m_req/wr/size/addr/wdata          downstream request (from latched copy)
//   m_addr_ok/data_ok/rdata           downstream handshakes and read data
//   busy                              a transaction is in flight
//   owner                             owner of current/last txn (1 = data)
//
// One transaction at a time: the winner is latched in IDLE, so requesters
// may drop req right after addr_ok; data_ok is routed only to the owner.

module sram_like_arbiter #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        owner_q;
    logic        last_win_q;

    logic        tie;
    logic        pick_data;
    logic        grant;
    logic        done;

    // On a tie in round-robin mode the side that did not win last time wins.
    always_comb begin
        tie = inst_req & data_req;
        if (DATA_PRIORITY)
            pick_data = data_req;
        else if (tie)
            pick_data = ~last_win_q;
        else
            pick_data = data_req;
    end

    always_comb begin
        state_nxt    = state;
        grant        = 1'b0;
        done         = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        m_req        = 1'b0;
        busy         = 1'b1;
        unique case (state)
            IDLE: begin
                busy         = 1'b0;
                grant        = inst_req | data_req;
                inst_addr_ok = grant & ~pick_data;
                data_addr_ok = grant & pick_data;
                if (grant)
                    state_nxt = REQ;
            end
            REQ: begin
                m_req = 1'b1;
                if (m_addr_ok)
                    state_nxt = WAIT;
            end
            WAIT: begin
                done         = m_data_ok;
                inst_data_ok = done & ~owner_q;
                data_data_ok = done & owner_q;
                if (done)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            size_q     <= 2'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            owner_q    <= 1'b0;
            last_win_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                owner_q <= pick_data;
                wr_q    <= pick_data ? data_wr    : inst_wr;
                size_q  <= pick_data ? data_size  : inst_size;
                addr_q  <= pick_data ? data_addr  : inst_addr;
                wdata_q <= pick_data ? data_wdata : inst_wdata;
                if (!DATA_PRIORITY && tie)
                    last_win_q <= pick_data;
            end
        end
    end

    assign m_wr       = wr_q;
    assign m_size     = size_q;
    assign m_addr     = addr_q;
    assign m_wdata    = wdata_q;
    assign owner      = owner_q;
    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: table-driven vectors plus hand sequences, with a
// response scoreboard; dut1 uses data priority, dut0 round-robin.

module tb_sram_like_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    logic        i_aok1, i_dok1, d_aok1, d_dok1, m_req1, m_wr1, busy1, own1;
    logic [1:0]  m_size1;
    logic [31:0] i_rd1, d_rd1, m_addr1, m_wdata1;
    logic        i_aok0, i_dok0, d_aok0, d_dok0, m_req0, m_wr0, busy0, own0;
    logic [1:0]  m_size0;
    logic [31:0] i_rd0, d_rd0, m_addr0, m_wdata0;

    sram_like_arbiter #(.DATA_PRIORITY(1'b1)) dut1 (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(i_aok1), .inst_data_ok(i_dok1), .inst_rdata(i_rd1),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(d_aok1), .data_data_ok(d_dok1), .data_rdata(d_rd1),
        .m_req(m_req1), .m_wr(m_wr1), .m_size(m_size1),
        .m_addr(m_addr1), .m_wdata(m_wdata1),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy1), .owner(own1)
    );

    sram_like_arbiter #(.DATA_PRIORITY(1'b0)) dut0 (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(i_aok0), .inst_data_ok(i_dok0), .inst_rdata(i_rd0),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(d_aok0), .data_data_ok(d_dok0), .data_rdata(d_rd0),
        .m_req(m_req0), .m_wr(m_wr0), .m_size(m_size0),
        .m_addr(m_addr0), .m_wdata(m_wdata0),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy0), .owner(own0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ireq, dreq, maok, mdok;
        logic [31:0] rdata;
        logic [5:0]  exp;
        logic        own;
        logic        chkm;
        logic [66:0] m;
        logic [31:0] push_rd;
    } vec_t;

    typedef struct {
        logic        side;
        logic [31:0] rd;
    } sb_t;

    vec_t vec[17];
    sb_t  sbq[$];
    int   nchk = 0;
    int   nerr = 0;
    int   idok_cnt = 0;

    task automatic chk(input string nm, input logic [66:0] act,
                       input logic [66:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic side, input logic [31:0] rd);
        sb_t e;
        e.side = side;
        e.rd   = rd;
        sbq.push_back(e);
    endtask

    task automatic sample();
        sb_t e;
        @(negedge clk);
        idok_cnt += int'(i_dok1);
        if (i_dok1 && d_dok1) begin
            nchk++;
            nerr++;
            $display("FAIL sb_both_dok: got 11 want one-hot");
        end else if (i_dok1 || d_dok1) begin
            if (sbq.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL sb_unexpected: got dok i=%b d=%b want none",
                         i_dok1, d_dok1);
            end else begin
                e = sbq.pop_front();
                chk("sb_owner", {66'd0, d_dok1}, {66'd0, e.side});
                chk("sb_rdata", {35'd0, d_dok1 ? d_rd1 : i_rd1},
                    {35'd0, e.rd});
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [66:0] outs1();
        return {52'd0, i_aok1, d_aok1, i_dok1, d_dok1, m_req1, busy1, own1,
                m_wr1, m_size1, m_wdata1 != 0, m_addr1 != 0};
    endfunction

    function automatic logic [66:0] outs0();
        return {52'd0, i_aok0, d_aok0, i_dok0, d_dok0, m_req0, busy0, own0,
                m_wr0, m_size0, m_wdata0 != 0, m_addr0 != 0};
    endfunction

    initial begin
        logic [3:0] rr;
        int         ph;
        resetn     = 1'b0;
        inst_req   = 1'b0;
        inst_wr    = 1'b0;
        inst_size  = 2'd2;
        inst_addr  = 32'hBFC0_0000;
        inst_wdata = 32'd0;
        data_req   = 1'b0;
        data_wr    = 1'b1;
        data_size  = 2'd2;
        data_addr  = 32'h8000_0010;
        data_wdata = 32'h1234_ABCD;
        m_addr_ok  = 1'b0;
        m_data_ok  = 1'b0;
        m_rdata    = 32'd0;

        vec[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b100000, 1'b0,
                    1'b0, 67'h0, 32'h3C08_0001};
        vec[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000011, 1'b0,
                    1'b1, {1'b0, 2'd2, 32'hBFC0_0000, 32'h0}, 32'h0};
        vec[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h3C08_0001, 6'b001001, 1'b0,
                    1'b0, 67'h0, 32'h0};
        vec[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0,
                    1'b0, 67'h0, 32'h0};
        vec[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 6'b010000, 1'b0,
                    1'b0, 67'h0, 32'h0};
        vec[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000011, 1'b1,
                    1'b1, {1'b1, 2'd2, 32'h8000_0010, 32'h1234_ABCD}, 32'h0};
        vec[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 6'b000101, 1'b1,
                    1'b0, 67'h0, 32'h0};
        vec[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b100000, 1'b1,
                    1'b0, 67'h0, 32'hDEAD_BEEF};
        vec[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000011, 1'b0,
                    1'b1, {1'b0, 2'd2, 32'hBFC0_0000, 32'h0}, 32'h0};
        vec[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 6'b001001, 1'b0,
                    1'b0, 67'h0, 32'h0};
        vec[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 6'b000000, 1'b0,
                    1'b0, 67'h0, 32'h0};
        vec[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0,
                    1'b0, 67'h0, 32'h0};
        vec[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 6'b100000, 1'b0,
                    1'b0, 67'h0, 32'h1111_2222};
        vec[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 6'b000011, 1'b0,
                    1'b0, 67'h0, 32'h0};
        vec[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 6'b000011, 1'b0,
                    1'b0, 67'h0, 32'h0};
        vec[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_2222, 6'b001001, 1'b0,
                    1'b0, 67'h0, 32'h0};
        vec[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 6'b000000, 1'b0,
                    1'b0, 67'h0, 32'h0};

        // reset state
        #12;
        chk("rst_outs1", outs1(), 67'd0);
        chk("rst_outs0", outs0(), 67'd0);
        adv();
        resetn = 1'b1;
        adv();

        // vector table
        for (int i = 0; i < 17; i++) begin
            inst_req  = vec[i].ireq;
            data_req  = vec[i].dreq;
            m_addr_ok = vec[i].maok;
            m_data_ok = vec[i].mdok;
            m_rdata   = vec[i].rdata;
            sample();
            chk($sformatf("vec%0d_ctl", i),
                {61'd0, i_aok1, d_aok1, i_dok1, d_dok1, m_req1, busy1},
                {61'd0, vec[i].exp});
            chk($sformatf("vec%0d_own", i), {66'd0, own1},
                {66'd0, vec[i].own});
            if (vec[i].chkm)
                chk($sformatf("vec%0d_m", i),
                    {m_wr1, m_size1, m_addr1, m_wdata1}, vec[i].m);
            if (vec[i].exp[5] || vec[i].exp[4])
                push(vec[i].exp[4], vec[i].push_rd);
            adv();
        end
        m_data_ok = 1'b0;

        // delayed slave, requester changes addr after addr_ok
        idok_cnt  = 0;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0100;
        sample();
        chk("dly_aok", {66'd0, i_aok1}, 67'd1);
        push(1'b0, 32'hA5A5_0001);
        adv();
        inst_req  = 1'b0;
        inst_addr = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            m_addr_ok = (k == 3);
            sample();
            chk("dly_req_mreq", {66'd0, m_req1}, 67'd1);
            chk("dly_req_addr", {35'd0, m_addr1}, {35'd0, 32'hBFC0_0100});
            adv();
        end
        m_addr_ok = 1'b0;
        m_rdata   = 32'hA5A5_0001;
        for (int k = 0; k < 6; k++) begin
            m_data_ok = (k == 5);
            sample();
            chk("dly_wait_mreq", {66'd0, m_req1}, 67'd0);
            chk("dly_wait_addr", {35'd0, m_addr1}, {35'd0, 32'hBFC0_0100});
            adv();
        end
        m_data_ok = 1'b0;
        sample();
        adv();
        chk("dly_one_dok", 67'(idok_cnt), 67'd1);

        // reset while in WAIT
        data_wr   = 1'b0;
        data_addr = 32'h8000_0020;
        data_req  = 1'b1;
        sample();
        chk("rw_aok", {66'd0, d_aok1}, 67'd1);
        push(1'b1, 32'h0);
        adv();
        data_req  = 1'b0;
        m_addr_ok = 1'b1;
        sample();
        adv();
        m_addr_ok = 1'b0;
        #1;
        resetn = 1'b0;
        #1;
        chk("rw_outs1", outs1(), 67'd0);
        chk("rw_outs0", outs0(), 67'd0);
        sbq.delete();
        m_data_ok = 1'b1;
        sample();
        chk("rw_stray", {65'd0, i_dok1 | d_dok1, i_dok0 | d_dok0}, 67'd0);
        adv();
        m_data_ok = 1'b0;
        resetn    = 1'b1;
        adv();
        data_req = 1'b1;
        sample();
        chk("rw_fresh_aok", {66'd0, d_aok1}, 67'd1);
        push(1'b1, 32'h0BAD_F00D);
        adv();
        data_req  = 1'b0;
        m_addr_ok = 1'b1;
        sample();
        chk("rw_fresh_mreq", {33'd0, m_req1, m_addr1}, {33'd1, 32'h8000_0020});
        adv();
        m_addr_ok = 1'b0;
        m_data_ok = 1'b1;
        m_rdata   = 32'h0BAD_F00D;
        sample();
        adv();
        m_data_ok = 1'b0;

        // round-robin ties on dut0 (fresh reset so last winner = inst)
        resetn = 1'b0;
        adv();
        resetn   = 1'b1;
        adv();
        rr       = 4'b0101;
        inst_req = 1'b1;
        data_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            ph        = c % 3;
            m_addr_ok = (ph == 1);
            m_data_ok = (ph == 2);
            m_rdata   = 32'hC0DE_0000 + 32'(c);
            sample();
            if (ph == 0) begin
                chk($sformatf("rr%0d_dut0", c / 3), {65'd0, d_aok0, i_aok0},
                    {65'd0, rr[c / 3], ~rr[c / 3]});
                chk($sformatf("rr%0d_dut1", c / 3), {66'd0, d_aok1}, 67'd1);
                push(1'b1, 32'hC0DE_0000 + 32'(c + 2));
            end
            if (ph == 2)
                chk($sformatf("rr%0d_dok0", c / 3), {65'd0, d_dok0, i_dok0},
                    {65'd0, rr[c / 3], ~rr[c / 3]});
            adv();
        end
        inst_req  = 1'b0;
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        sample();
        adv();

        chk("sb_drained", 67'(sbq.size()), 67'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
